fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Two-requester scheduler that shares a single combinational `fp_mul` instance (32-bit IEEE-754 single precision, 3-bit rounding mode, overflow/underflow flags) between two independent clients. Requests are accepted with a valid/ready handshake, granted round-robin, executed with registered operands, and returned on a per-requester response channel with valid/ready backpressure. The block sits between the ALU issue logic and the shared multiplier so both issue ports can use one multiplier.

## Interface
- `CNT_W`, 16, width of the completed-operation counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester request valid, index 0/1.
- `req_ready` out 2: per-requester request accept.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32 each: operands.
- `req0_rmode`, `req1_rmode` in 3 each: rounding mode passed to `fp_mul.r_mode`.
- `rsp_valid` out 2: per-requester result valid.
- `rsp_ready` in 2: per-requester result accept.
- `rsp_z` out 32: product, shared by both channels and qualified by `rsp_valid`.
- `rsp_ovrf`, `rsp_udrf` out 1 each: flags from `fp_mul`.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out `CNT_W`: completed operations, saturating.

## Operation
- FSM states:
  - IDLE: `req_ready` is high for the granted index only, combinationally from `req_valid` and `last_grant`.
    - If exactly one request is valid, grant that requester.
    - If both are valid, grant the index that is not `last_grant`.
    - On handshake (`req_valid[g] && req_ready[g]`), register a, b, rmode and the grant id `g`, set `last_grant <= g`, then go to EXEC.
  - EXEC: the registered operands drive `fp_mul`. At the end of the cycle, capture `fp_Z`, `ovrf` and `udrf` into the response registers, then go to RESP.
  - RESP: `rsp_valid[g]=1`, all other `rsp_valid` bits are 0. Outputs stay stable until `rsp_ready[g]`. On that handshake, increment `op_count` (hold at all-ones) and go to IDLE.
- `req_ready` is 0 in EXEC and RESP. The block never accepts a new request while an op is in flight (depth 1).
- `rsp_ready` of the non-granted index is ignored.
- `rsp_z`/flags hold their last captured value outside RESP.
- Operands and results pass through unmodified; all arithmetic is inside `fp_mul`. Commutativity of `fp_mul` is not relied on: `a` is always driven to `fp_X` and `b` to `fp_Y`.

## Timing
- Reset values:
  - State is IDLE; `last_grant` is 1, so requester 0 wins the first contention.
  - All captured operand and response registers, and `op_count`, are 0.
  - `rsp_valid` is 0 and `busy` is 0.
  - `req_ready` is 0 during reset and follows the IDLE rules once reset is released.
- Latency:
  - Request handshake in cycle N.
  - EXEC in N+1.
  - `rsp_valid` high in N+2.
  - If `rsp_ready` is already high in N+2, IDLE in N+3 and the next accept can occur in N+3.
  - Peak throughput is 1 op per 3 cycles.
- Backpressure: RESP may last any number of cycles; `rsp_*` must not change while `rsp_valid` is high and unacknowledged.
- Fairness: under continuous requests on both channels, grants strictly alternate 0,1,0,1…
- Simultaneous events:
  - A request from the other index arriving during RESP waits and is granted in the next IDLE.
  - A requester may hold `req_valid` while its own response is pending; it is re-granted only if the other requester is idle.
- Reset mid-operation (any state): the in-flight op is dropped immediately, outputs return to reset values and no response is produced.
- `op_count` saturation: at all-ones it stays all-ones on further completions.

## Test plan
- Single op, requester 0: a=0x40000000 (2.0), b=0x40400000 (3.0), rmode=0, accept at cycle N. Required: `rsp_valid=2'b01` at N+2, `rsp_z=0x40C00000`, ovrf=0, udrf=0, `op_count=1` after the response handshake.
- Contention from reset: both `req_valid` high with identical operands 0x3F800000×0x3F800000. Required: grants occur in the order 0, 1, 0, 1 over 4 ops, each `rsp_z=0x3F800000`, and responses are 3 cycles apart.
- Backpressure: `rsp_ready[1]=0` for 5 cycles during a req1 op of 0x7F000000×0x7F000000 (rmode=0). Required: `rsp_valid[1]` and `rsp_z`/`rsp_ovrf` stay stable for all 5 cycles, `ovrf=1`, and `req_ready=0` throughout.
- Underflow pass-through: 0x00800000×0x00800000 on req0. Required: `rsp_udrf=1`, matching a standalone `fp_mul` result bit-exactly.
- Reset mid-EXEC: assert `rst_n=0` during the EXEC cycle. Required: `busy=0` and `rsp_valid=0` immediately, `op_count=0`, and no response after reset is released.
- Counter saturation with `CNT_W=2`: run 5 ops. Required: `op_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one combinational single-precision multiplier between
// two requesters. Requests are accepted one at a time with round-robin
// arbitration. Operands are registered, multiplied for one cycle, and the
// product is returned on the winner's response channel.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   req{0,1}_a/_b/_rmode     operands and rounding mode
//   rsp_valid/rsp_ready[1:0] per-requester response handshake
//   rsp_z, rsp_ovrf, rsp_udrf shared result, qualified by rsp_valid
//   busy                     high whenever an op is in flight
//   op_count                 saturating count of completed ops
//
// fp_mul: combinational IEEE-754 single-precision multiply.
//   r_mode: 0 RNE, 1 RTZ, 2 toward -inf, 3 toward +inf, 4 nearest/ties-away,
//   other codes behave as RNE.
//   Subnormal inputs are read as zero. Results below the normal range flush
//   to signed zero and raise udrf. Overflow raises ovrf and returns inf or
//   max-finite, depending on the rounding direction.

module fp_mul (
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);
  logic              s;
  logic [7:0]        ex, ey;
  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [47:0]       prod;
  logic [23:0]       mant;
  logic              g, st, inc, max_fin;
  logic [24:0]       mr;
  logic [22:0]       frac_o;
  logic signed [9:0] e, e_r;

  assign s      = fp_X[31] ^ fp_Y[31];
  assign ex     = fp_X[30:23];
  assign ey     = fp_Y[30:23];
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign x_inf  = (ex == 8'hFF) && (fp_X[22:0] == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (fp_Y[22:0] == 23'd0);
  assign x_nan  = (ex == 8'hFF) && (fp_X[22:0] != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (fp_Y[22:0] != 23'd0);
  assign prod   = {1'b1, fp_X[22:0]} * {1'b1, fp_Y[22:0]};

  always_comb begin
    fp_Z    = 32'd0;
    ovrf    = 1'b0;
    udrf    = 1'b0;
    max_fin = 1'b0;
    // The product of two [1,2) significands is in [1,4); bit 47 selects the
    // normalisation shift.
    if (prod[47]) begin
      mant = prod[47:24];
      g    = prod[23];
      st   = |prod[22:0];
    end else begin
      mant = prod[46:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    e = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127
        + $signed({9'd0, prod[47]});
    case (r_mode)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & (g | st);
      3'd3:    inc = ~s & (g | st);
      3'd4:    inc = g;
      default: inc = g & (st | mant[0]);
    endcase
    mr = {1'b0, mant} + {24'd0, inc};
    // A rounding carry out of the significand leaves the fraction as zero and
    // bumps the exponent.
    if (mr[24]) begin
      frac_o = mr[23:1];
      e_r    = e + 10'sd1;
    end else begin
      frac_o = mr[22:0];
      e_r    = e;
    end
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      fp_Z = 32'h7FC0_0000;
    end else if (x_inf || y_inf) begin
      fp_Z = {s, 8'hFF, 23'd0};
    end else if (x_zero || y_zero) begin
      fp_Z = {s, 31'd0};
    end else if (e <= 10'sd0) begin
      fp_Z = {s, 31'd0};
      udrf = 1'b1;
    end else if (e_r >= 10'sd255) begin
      ovrf    = 1'b1;
      max_fin = (r_mode == 3'd1) || ((r_mode == 3'd2) && !s) ||
                ((r_mode == 3'd3) && s);
      fp_Z    = max_fin ? {s, 8'hFE, 23'h7F_FFFF} : {s, 8'hFF, 23'd0};
    end else begin
      fp_Z = {s, e_r[7:0], frac_o};
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_rmode,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_rmode,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_z,
  output logic             rsp_ovrf,
  output logic             rsp_udrf,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
  } req_t;

  typedef struct packed {
    logic [31:0] z;
    logic        ovrf;
    logic        udrf;
  } rsp_t;

  state_t            state_q, state_d;
  req_t              op_q, op_d;
  rsp_t              res_q, res_d, mul_out;
  req_t [1:0]        req_in;
  logic              last_q, last_d, gnt_q, gnt_d, sel, fire;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign req_in[0] = '{a: req0_a, b: req0_b, rm: req0_rmode};
  assign req_in[1] = '{a: req1_a, b: req1_b, rm: req1_rmode};

  // A lone requester wins outright; on contention the one not served last wins.
  assign sel  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  // Gated by rst_n so nothing looks accepted while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE) && req_valid[sel]) ?
                     (2'b01 << sel) : 2'b00;
  assign fire = |(req_valid & req_ready);

  fp_mul u_fp_mul (
    .fp_X   (op_q.a),
    .fp_Y   (op_q.b),
    .r_mode (op_q.rm),
    .fp_Z   (mul_out.z),
    .ovrf   (mul_out.ovrf),
    .udrf   (mul_out.udrf)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    res_d       = res_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (fire) begin
        op_d    = req_in[sel];
        gnt_d   = sel;
        last_d  = sel;
        busy_d  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        res_d       = mul_out;
        rsp_valid_d = 2'b01 << gnt_q;
        state_d     = RESP;
      end
      RESP: if (rsp_ready[gnt_q]) begin
        rsp_valid_d = 2'b00;
        busy_d      = 1'b0;
        state_d     = IDLE;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: begin
        rsp_valid_d = 2'b00;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      res_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_q       <= res_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = res_q.z;
  assign rsp_ovrf  = res_q.ovrf;
  assign rsp_udrf  = res_q.udrf;
  assign busy      = busy_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_z;
  logic [2:0]  req0_rmode, req1_rmode;
  logic        rsp_ovrf, rsp_udrf, busy;
  logic [15:0] op_count;
  // narrow-counter copy sees identical traffic
  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [31:0] s_rsp_z;
  logic        s_rsp_ovrf, s_rsp_udrf, s_busy;
  logic [1:0]  s_op_count;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_rmode(req0_rmode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_rmode(req1_rmode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .busy(busy), .op_count(op_count)
  );

  fp_mul_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_rmode(req0_rmode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_rmode(req1_rmode),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_z(s_rsp_z),
    .rsp_ovrf(s_rsp_ovrf), .rsp_udrf(s_rsp_udrf), .busy(s_busy),
    .op_count(s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, b, input logic [2:0] rm);
    if (idx == 0) begin req0_a = a; req0_b = b; req0_rmode = rm; end
    else          begin req1_a = a; req1_b = b; req1_rmode = rm; end
  endtask

  // Called just after a negedge with the block idle; returns just after the
  // negedge following the response handshake.
  task automatic run_op(input int idx, input logic [31:0] a, b, input logic [2:0] rm,
                        input int stall, input logic [31:0] ez,
                        input logic eo, eu, input logic hold_other);
    int n;
    logic [1:0] one;
    one = 2'b01 << idx;
    set_req(idx, a, b, rm);
    req_valid[idx] = 1'b1;
    rsp_ready = (stall == 0) ? one : 2'b00;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 20) begin @(negedge clk); #1; n++; end
    chk("acc_wait", n, 0);
    @(negedge clk);               // EXEC
    req_valid[idx] = 1'b0;
    chk("exec_busy", {busy, rsp_valid}, {1'b1, 2'b00});
    @(negedge clk);               // RESP expected now
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("rsp_lat", n, 0);
    for (int i = 0; i < stall; i++) begin
      if (hold_other) req_valid[1-idx] = 1'b1;
      #1;
      chk("bp_vld", rsp_valid, one);
      chk("bp_res", {rsp_z, rsp_ovrf, rsp_udrf}, {ez, eo, eu});
      chk("bp_rdy", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = one;
    chk("rsp_vld", rsp_valid, one);
    chk("rsp_res", {rsp_z, rsp_ovrf, rsp_udrf}, {ez, eo, eu});
    @(negedge clk);               // back in IDLE
    rsp_ready = 2'b00;
    chk("post_vld", {busy, rsp_valid}, 3'b000);
    if (hold_other) begin
      #1;
      chk("waiter_rdy", req_ready, 2'b01 << (1 - idx));
      req_valid[1-idx] = 1'b0;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_rdy", req_ready, 2'b00);
    chk("rst_out", {rsp_valid, busy, rsp_z, rsp_ovrf, rsp_udrf}, 37'd0);
    chk("rst_cnt", {op_count, s_op_count}, 18'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : main
    int seen, last_c, c;
    logic [1:0] exp_v;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = 0; req0_b = 0; req0_rmode = 0; req1_a = 0; req1_b = 0; req1_rmode = 0;
    do_reset();

    // 2.0 * 3.0 on requester 0
    run_op(0, 32'h4000_0000, 32'h4040_0000, 3'd0, 0, 32'h40C0_0000, 1'b0, 1'b0, 1'b0);
    chk("cnt_after1", op_count, 16'd1);

    // (1+2^-23)^2: RNE truncates, round-to-+inf bumps the lsb
    run_op(0, 32'h3F80_0001, 32'h3F80_0001, 3'd0, 0, 32'h3F80_0002, 1'b0, 1'b0, 1'b0);
    run_op(1, 32'h3F80_0001, 32'h3F80_0001, 3'd3, 0, 32'h3F80_0003, 1'b0, 1'b0, 1'b0);
    // operand order: (-2) * 3 = -6
    run_op(1, 32'hC000_0000, 32'h4040_0000, 3'd0, 0, 32'hC0C0_0000, 1'b0, 1'b0, 1'b0);

    // backpressure on req1 with overflow; req0 waits during RESP
    run_op(1, 32'h7F00_0000, 32'h7F00_0000, 3'd0, 5, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    // overflow under RTZ saturates to max finite
    run_op(1, 32'h7F00_0000, 32'h7F00_0000, 3'd1, 0, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0);
    // underflow flush: 2^-126 * 2^-126
    run_op(0, 32'h0080_0000, 32'h0080_0000, 3'd0, 0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    chk("cnt_after7", {op_count, s_op_count}, {16'd7, 2'd3});

    // reset during EXEC
    set_req(0, 32'h4000_0000, 32'h4000_0000, 3'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {busy, rsp_valid, req_ready}, 5'd0);
    chk("mid_rst_cnt", {op_count, s_op_count}, 18'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid != 2'b00) seen++; end
    chk("mid_rst_norsp", seen, 0);
    chk("mid_rst_idle", {busy, op_count}, 17'd0);

    // contention: strict alternation starting at 0, 3 cycles apart
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0);
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 3'd0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    chk("cont_rdy0", req_ready, 2'b01);
    seen = 0; last_c = -1; c = 0;
    while (seen < 4 && c < 40) begin
      @(negedge clk);
      c++;
      if (rsp_valid != 2'b00) begin
        exp_v = (seen % 2 == 0) ? 2'b01 : 2'b10;
        chk("cont_order", rsp_valid, exp_v);
        chk("cont_z", rsp_z, 32'h3F80_0000);
        chk("cont_gap", c - last_c, (seen == 0) ? c + 1 : 3);
        last_c = c;
        seen++;
        if (seen == 4) req_valid = 2'b00;
      end
    end
    chk("cont_count", seen, 4);
    @(negedge clk);
    chk("cont_cnt", {op_count, s_op_count}, {16'd4, 2'd3});

    // saturation of the 2-bit counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      run_op(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      chk("sat_cnt", s_op_count, (k > 3) ? 2'd3 : k[1:0]);
      chk("wide_cnt", op_count, k[15:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
